// File: rtl/dmem_lsu.sv
// Load/store unit: turns core load/store requests into aligned, handshaked
// word accesses on the data-memory bus, stalls the core until the access
// completes and reports misaligned accesses, bus errors and timeouts.
module dmem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic             access;
    logic             size_b;
    logic             size_h;
    logic             size_w;
    logic             misaligned;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [31:0]      lane;
    logic [31:0]      load_ext;

    // Decode the incoming request: access size, alignment, enables and lane data.
    always_comb begin
        access     = mem_read | mem_write;
        // funct3[1:0] = 1x is a word access (011 included).
        size_w     = funct3[1];
        size_h     = (funct3[1:0] == 2'b01);
        size_b     = (funct3[1:0] == 2'b00);
        misaligned = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));

        be_next    = 4'b1111;
        wdata_next = wdata;
        if (size_b) begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
        end else if (size_h) begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
        end
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        lane     = bus_rdata >> {off_q, 3'b000};
        load_ext = lane;
        if (f3_q[1:0] == 2'b00) begin
            load_ext = f3_q[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        end else if (f3_q[1:0] == 2'b01) begin
            load_ext = f3_q[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        end
    end

    // Core stall: held while a new access is being accepted and for the whole request.
    always_comb begin
        stall = reset & (((state == StIdle) & access) | (state == StReq));
    end

    // Access FSM with registered bus, fault and load-result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            cnt         <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rdata       <= 32'h0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A late ack arriving here belongs to an abandoned request; ignore it.
                    if (access) begin
                        if (misaligned) begin
                            state       <= StFault;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                            rdata       <= 32'h0;
                        end else begin
                            state     <= StReq;
                            cnt       <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= mem_write ? wdata_next : 32'h0;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                        end
                    end
                end
                StReq: begin
                    // Ack has priority over an expiring counter.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            state       <= StFault;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_BUS_ERR;
                            rdata       <= 32'h0;
                        end else begin
                            state <= StDone;
                            if (!bus_we) begin
                                rdata <= load_ext;
                            end
                        end
                    end else if (cnt == CNT_LAST) begin
                        state       <= StFault;
                        bus_req     <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        rdata       <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                StFault: begin
                    state       <= StIdle;
                    fault       <= 1'b0;
                    fault_cause <= 2'b00;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the single-cycle core datapath and a handshaked data-memory bus. Takes the ALU-computed address, store data and funct3 from the core; generates aligned word requests with byte enables; returns sign/zero-extended load data to the result mux. Stalls the core until the bus acknowledges, and reports misaligned accesses, bus errors and timeouts as faults.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without bus_ack before a timeout fault (≥1)

- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store; wins if both high
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; funct3[1:0]=11 decodes as W
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and suppress regfile write
- rdata  out  32  extended load result
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout
- bus_req  out  1  request valid
- bus_we  out  1  write request
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  slave completes request
- bus_err  in  1  error, valid only with bus_ack
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE: access = mem_read|mem_write. Aligned access → register we, bus_addr, bus_be, bus_wdata, funct3, addr[1:0]; go REQ. Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠00) → go FAULT, cause 01, no bus request.
- REQ: bus_req=1, all bus_* outputs stable from registered values. bus_ack & !bus_err → DONE; bus_ack & bus_err → FAULT cause 10; counter reaches TIMEOUT_CYCLES → FAULT cause 11, bus_req drops.
- DONE / FAULT: one cycle; core commits; mem_read/mem_write ignored (they belong to the completing instruction); → IDLE.
- stall = (IDLE & access) | REQ; 0 in DONE, FAULT, and while reset is low.
- Byte enables: B → 0001<<addr[1:0]; H → addr[1] ? 1100 : 0011; W → 1111. Loads use the same bus_be, with bus_we=0 and bus_wdata=0.
- Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- Load: lane = bus_rdata >> (8*offset). B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through. The result is captured into rdata on the ack cycle.
- rdata is held until the next load completes; it is cleared to 0 on any fault and is unchanged by stores.
- fault and fault_cause are asserted only in FAULT; otherwise 0/00.

## Timing
- Reset (async, low): state IDLE; stall, bus_req, bus_we, fault = 0; bus_addr, bus_be, bus_wdata, rdata = 0; fault_cause = 00; timeout counter = 0.
- A reset during REQ abandons the transaction immediately. A late bus_ack seen in IDLE is ignored.
- Zero-wait access: cycle 0 IDLE (stall=1), cycle 1 REQ with ack (stall=1), cycle 2 DONE (stall=0, rdata valid). A load with N wait states stalls 2+N cycles.
- bus_ack may arrive in the first REQ cycle; the slave may respond combinationally.
- Misaligned access: cycle 0 IDLE stall=1, cycle 1 FAULT stall=0.
- Timeout: bus_req is high for exactly TIMEOUT_CYCLES cycles, then FAULT. The counter clears on REQ entry.
- An ack in the same cycle the counter expires counts as success.

## Test plan
- LW addr 0x100, ack in first REQ cycle with bus_rdata 0xDEADBEEF → bus_addr 0x100, bus_be 1111, stall high 2 cycles, DONE rdata 0xDEADBEEF.
- LB addr 0x103, bus_rdata 0x80FF0000, 3 wait states → bus_be 1000, stall 5 cycles, rdata 0xFFFFFF80. Repeat as LBU → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SH addr 0x206, wdata 0x1234ABCD → bus_addr 0x204, bus_we 1, bus_be 1100, bus_wdata 0xABCDABCD; rdata unchanged.
- LW addr 0x102 → bus_req never asserted, stall 1 cycle, then fault=1 with cause 01 for one cycle, rdata 0.
- TIMEOUT_CYCLES=4, no ack → bus_req high 4 cycles, fault cause 11. Separately, ack+err → fault cause 10.
- reset low mid-REQ → all outputs 0 immediately; a late ack after release is ignored; a following LW 0x100 completes normally.
